// File: rtl/axis_dsm_cic_decimator.sv
// axis_dsm_cic_decimator
// Receive side of the first-order delta-sigma link: a second-order CIC (sinc^2) decimator that
// turns the 1-bit modulator stream into signed WIDTH-bit PCM samples over AXI-Stream.
// Optional feature macro: DSM_CIC_SAT_COUNT_EN adds the 16-bit sat_cnt clipped-sample counter.

module axis_dsm_cic_decimator #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned DECIM_LOG2 = 6
) (
   input  logic             aclk,
   input  logic             arst_n,
   input  logic             s_axis_data_tdata,
   input  logic             s_axis_data_tvalid,
   output logic             s_axis_data_tready,
   output logic [WIDTH-1:0] m_axis_data_tdata,
   output logic             m_axis_data_tvalid,
   input  logic             m_axis_data_tready
`ifdef DSM_CIC_SAT_COUNT_EN
   ,
   output logic [15:0]      sat_cnt
`endif
);

   localparam int unsigned D  = DECIM_LOG2;
   localparam int unsigned WI = 2 * D + 2;  // integrator / comb width
   localparam int unsigned YW = 2 * D;      // scaled sample width before output alignment

   // R^2/2 in integrator width; used both as the mid-scale offset and the clip threshold
   localparam logic [WI-1:0] HalfR2 = {{(WI - YW){1'b0}}, 1'b1, {(YW - 1){1'b0}}};

   // State
   logic [WI-1:0]    i1_q, i1_d;
   logic [WI-1:0]    i2_q, i2_d;
   logic [WI-1:0]    d1_q, d2_q;
   logic [D-1:0]     cnt_q;
   logic [1:0]       wu_q;
   logic [WIDTH-1:0] tdata_q, tdata_d;
   logic             tvalid_q, tvalid_d;

   // Datapath
   logic                 accept;
   logic                 cnt_last;
   logic                 boundary;
   logic                 warm;
   logic                 load;
   logic [WI-1:0]        c1, c2, y;
   logic                 sat;
   logic signed [YW-1:0] y_clip;
   logic [WIDTH-1:0]     y_out;

   assign cnt_last = (cnt_q == {D{1'b1}});

   // Stall only when the upcoming boundary beat would overwrite an unaccepted sample
   assign s_axis_data_tready = !(tvalid_q && !m_axis_data_tready && cnt_last);

   assign accept   = s_axis_data_tvalid && s_axis_data_tready;
   assign boundary = accept && cnt_last;
   assign warm     = (wu_q == 2'd2);
   assign load     = boundary && warm;

   // Integrators, comb stages and scaling for the current beat
   always_comb begin
      i1_d   = i1_q + WI'(s_axis_data_tdata);
      i2_d   = i2_q + i1_d;
      c1     = i2_d - d1_q;
      c2     = c1 - d2_q;
      y      = c2 - HalfR2;
      // Only +R^2/2 is out of the 2D-bit signed range
      sat    = (y == HalfR2);
      y_clip = sat ? {1'b0, {(YW - 1){1'b1}}} : y[YW-1:0];
   end

   // Align the 2D-bit result to the output width
   if (YW >= WIDTH) begin : g_shr
      localparam int unsigned Shr = YW - WIDTH;
      assign y_out = WIDTH'(y_clip >>> Shr);
   end else begin : g_shl
      assign y_out = {y_clip, {(WIDTH - YW){1'b0}}};
   end

   // Integrators, phase counter, comb delays and warm-up counter advance on accepted beats
   always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) begin
         i1_q  <= '0;
         i2_q  <= '0;
         d1_q  <= '0;
         d2_q  <= '0;
         cnt_q <= '0;
         wu_q  <= '0;
      end else if (accept) begin
         i1_q  <= i1_d;
         i2_q  <= i2_d;
         cnt_q <= cnt_q + {{(D - 1){1'b0}}, 1'b1};
         if (boundary) begin
            d1_q <= i2_d;
            d2_q <= c1;
            if (!warm) begin
               wu_q <= wu_q + 2'd1;
            end
         end
      end
   end

   // Output register next state: a load wins over a same-cycle handshake
   always_comb begin
      tvalid_d = tvalid_q;
      tdata_d  = tdata_q;
      if (load) begin
         tvalid_d = 1'b1;
         tdata_d  = y_out;
      end else if (tvalid_q && m_axis_data_tready) begin
         tvalid_d = 1'b0;
      end
   end

   // Output register
   always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) begin
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
      end else begin
         tvalid_q <= tvalid_d;
         tdata_q  <= tdata_d;
      end
   end

   assign m_axis_data_tvalid = tvalid_q;
   assign m_axis_data_tdata  = tdata_q;

`ifdef DSM_CIC_SAT_COUNT_EN
   logic [15:0] sat_cnt_q;

   // Count loaded samples that were clipped, saturating at all-ones
   always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) begin
         sat_cnt_q <= '0;
      end else if (load && sat && (sat_cnt_q != 16'hFFFF)) begin
         sat_cnt_q <= sat_cnt_q + 16'd1;
      end
   end

   assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_axis_dsm_cic_decimator.sv
// Directed bench for axis_dsm_cic_decimator (WIDTH=16, DECIM_LOG2=6 plus a DECIM_LOG2=10 instance).
// Expected samples come from a triangular-weight sinc^2 convolution over the accepted bit history.

module tb_axis_dsm_cic_decimator;

   localparam int R = 64;

   logic        aclk = 1'b0;
   logic        arst_n;
   logic        s_tdata, s_tvalid, s_tready;
   logic [15:0] m_tdata;
   logic        m_tvalid, m_tready;

   logic        rst10_n;
   logic        s10_tdata, s10_tvalid, s10_tready;
   logic [15:0] m10_tdata;
   logic        m10_tvalid, m10_tready;

`ifdef DSM_CIC_SAT_COUNT_EN
   logic [15:0] sat_cnt, sat_cnt10;
`endif

   always #5 aclk = ~aclk;

   axis_dsm_cic_decimator #(.WIDTH(16), .DECIM_LOG2(6)) dut (
      .aclk               (aclk),
      .arst_n             (arst_n),
      .s_axis_data_tdata  (s_tdata),
      .s_axis_data_tvalid (s_tvalid),
      .s_axis_data_tready (s_tready),
      .m_axis_data_tdata  (m_tdata),
      .m_axis_data_tvalid (m_tvalid),
      .m_axis_data_tready (m_tready)
`ifdef DSM_CIC_SAT_COUNT_EN
      ,
      .sat_cnt            (sat_cnt)
`endif
   );

   axis_dsm_cic_decimator #(.WIDTH(16), .DECIM_LOG2(10)) dut10 (
      .aclk               (aclk),
      .arst_n             (rst10_n),
      .s_axis_data_tdata  (s10_tdata),
      .s_axis_data_tvalid (s10_tvalid),
      .s_axis_data_tready (s10_tready),
      .m_axis_data_tdata  (m10_tdata),
      .m_axis_data_tvalid (m10_tvalid),
      .m_axis_data_tready (m10_tready)
`ifdef DSM_CIC_SAT_COUNT_EN
      ,
      .sat_cnt            (sat_cnt10)
`endif
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   int          nacc    = 0;
   int          n_out   = 0;
   bit          hist[$];
   logic [15:0] expq[$];
   bit          use_const = 1'b0;
   logic [15:0] const_val = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // sinc^2 response: triangular weights 1..R..1 over the last 2R-1 accepted bits
   function automatic logic [15:0] model_out();
      int n;
      int c2;
      int y;
      n  = hist.size();
      c2 = 0;
      for (int k = 0; k < 2 * R - 1; k++) begin
         int h;
         h = (k < R) ? k + 1 : 2 * R - 1 - k;
         if ((n - 1 - k) >= 0) begin
            if (hist[n - 1 - k]) c2 += h;
         end
      end
      y = c2 - R * R / 2;
      if (y == R * R / 2) y = R * R / 2 - 1;
      return 16'(y * 16);
   endfunction

   task automatic model_clear();
      hist.delete();
      expq.delete();
      nacc  = 0;
      n_out = 0;
   endtask

   // One clock: sample handshakes before the edge, update the scoreboard after it
   task automatic tick();
      logic        acc, hs, bd;
      logic [15:0] hd, ev;
      #1;
      acc = s_tvalid && s_tready;
      bd  = s_tdata;
      hs  = m_tvalid && m_tready;
      hd  = m_tdata;
      @(posedge aclk);
      #1;
      if (hs) begin
         n_out++;
         chk("sb_avail", 32'(expq.size() != 0), 32'd1);
         if (expq.size() != 0) begin
            ev = expq.pop_front();
            chk("sb_data", hd, ev);
         end
         if (use_const) chk("const_data", hd, const_val);
      end
      if (acc) begin
         hist.push_back(bd);
         nacc++;
         if ((nacc % R) == 0 && (nacc / R) >= 3) expq.push_back(model_out());
      end
   endtask

   task automatic do_reset();
      arst_n = 1'b0;
      @(posedge aclk);
      #1;
      model_clear();
      arst_n = 1'b1;
   endtask

   initial begin
      arst_n     = 1'b0;
      s_tdata    = 1'b0;
      s_tvalid   = 1'b0;
      m_tready   = 1'b0;
      rst10_n    = 1'b0;
      s10_tdata  = 1'b1;
      s10_tvalid = 1'b1;
      m10_tready = 1'b1;

      // Reset state
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_tdata", m_tdata, 0);
      chk("rst_tready", s_tready, 1);
`ifdef DSM_CIC_SAT_COUNT_EN
      chk("rst_satcnt", sat_cnt, 0);
`endif
      arst_n = 1'b1;
      model_clear();

      // All ones: clipped full scale
      use_const = 1'b1;
      const_val = 16'h7FF0;
      s_tvalid  = 1'b1;
      s_tdata   = 1'b1;
      m_tready  = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (nacc == 191) chk("ones_first_v_pre", m_tvalid, 0);
         if (nacc == 192) chk("ones_first_v", m_tvalid, 1);
      end
      s_tvalid = 1'b0;
      repeat (3) tick();
      chk("ones_count", n_out, 13);
`ifdef DSM_CIC_SAT_COUNT_EN
      chk("ones_satcnt", sat_cnt, 13);
`endif

      // All zeros: negative full scale
      do_reset();
      const_val = 16'h8000;
      s_tvalid  = 1'b1;
      s_tdata   = 1'b0;
      repeat (400) tick();
      s_tvalid = 1'b0;
      repeat (3) tick();
      chk("zeros_count", n_out, 4);
`ifdef DSM_CIC_SAT_COUNT_EN
      chk("zeros_satcnt", sat_cnt, 0);
`endif

      // Alternating 1,0: mid scale
      do_reset();
      const_val = 16'h0000;
      s_tvalid  = 1'b1;
      for (int i = 0; i < 400; i++) begin
         s_tdata = (i % 2 == 0);
         tick();
      end
      s_tvalid = 1'b0;
      repeat (3) tick();
      chk("alt_count", n_out, 4);

      // Backpressure: m_tready low for 300 cycles
      do_reset();
      const_val = 16'h7FF0;
      s_tvalid  = 1'b1;
      s_tdata   = 1'b1;
      m_tready  = 1'b0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (m_tvalid) chk("bp_hold", m_tdata, 16'h7FF0);
      end
      chk("bp_nacc", nacc, 255);
      chk("bp_stall", s_tready, 0);
      chk("bp_valid", m_tvalid, 1);
      m_tready = 1'b1;
      repeat (200) tick();
      s_tvalid = 1'b0;
      repeat (3) tick();
      chk("bp_count", n_out, nacc / R - 2);
      chk("bp_drained", expq.size(), 0);

      // Random gaps, data and backpressure
      do_reset();
      use_const = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         s_tvalid = 1'($urandom_range(0, 1));
         s_tdata  = 1'($urandom_range(0, 1));
         m_tready = 1'($urandom_range(0, 1));
         tick();
      end
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      repeat (3) tick();
      chk("rand_drained", expq.size(), 0);
      chk("rand_count", n_out, nacc / R - 2);

      // Reset pulse in the middle of a window
      do_reset();
      use_const = 1'b1;
      const_val = 16'h7FF0;
      s_tvalid  = 1'b1;
      s_tdata   = 1'b1;
      m_tready  = 1'b1;
      for (int i = 0; i < 300 && nacc < 256; i++) tick();
      m_tready = 1'b0;
      repeat (36) tick();
      chk("mid_pre_valid", m_tvalid, 1);
      arst_n = 1'b0;
      #1;
      chk("mid_async_drop", m_tvalid, 0);
      model_clear();
      @(posedge aclk);
      #1;
      arst_n   = 1'b1;
      m_tready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (nacc == 191) chk("mid_first_v_pre", m_tvalid, 0);
         if (nacc == 192) chk("mid_first_v", m_tvalid, 1);
      end
      s_tvalid = 1'b0;
      repeat (3) tick();
      chk("mid_count", n_out, 2);

      // DECIM_LOG2 = 10: right-shift alignment of the clipped full scale
      use_const = 1'b0;
      rst10_n   = 1'b1;
      for (int i = 1; i <= 4200; i++) begin
         tick();
         if (i == 3071) chk("d10_first_v_pre", m10_tvalid, 0);
         if (i == 3072) begin
            chk("d10_first_v", m10_tvalid, 1);
            chk("d10_data", m10_tdata, 16'h7FFF);
         end
         if (i == 4096) chk("d10_data2", m10_tdata, 16'h7FFF);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
